// File: rtl/sqrt_start_sequencer.sv
// rtl/sqrt_start_sequencer.sv - debounced start key, operand latch and st strobe train for the sqrt unit
// Optional strobe-count timeout enabled by defining SQRT_SEQ_TIMEOUT_EN.
module sqrt_start_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  HALF_PERIOD     = 8'd25,
  parameter logic [5:0]  MAX_STEPS       = 6'd40
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       key_n,
  input  logic [7:0] sw,
  input  logic       done_in,
  output logic [7:0] n_out,
  output logic       st_out,
  output logic       busy,
  output logic       result_valid,
  output logic [5:0] step_count,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, DONE, WAIT_REL} state_t;

  state_t      state;
  logic [1:0]  key_sync;
  logic [7:0]  sw_s1, sw_s2;
  logic [1:0]  done_sync;
  logic [15:0] db_cnt;
  logic        db_level, db_prev;
  logic [7:0]  ph;
  logic        press;

  // Synchronizers idle at the released key level so reset never looks like a press
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      key_sync  <= 2'b11;
      sw_s1     <= 8'd0;
      sw_s2     <= 8'd0;
      done_sync <= 2'b00;
    end else begin
      key_sync  <= {key_sync[0], key_n};
      sw_s1     <= sw;
      sw_s2     <= sw_s1;
      done_sync <= {done_sync[0], done_in};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      db_cnt   <= 16'd0;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
    end else begin
      db_prev <= db_level;
      if (key_sync[1] == db_level) begin
        db_cnt <= 16'd0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        db_level <= key_sync[1];
        db_cnt   <= 16'd0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  assign press = db_prev & ~db_level;

`ifndef SQRT_SEQ_TIMEOUT_EN
  localparam logic [5:0] unused_max_steps = MAX_STEPS;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      ph           <= 8'd0;
      n_out        <= 8'd0;
      st_out       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      step_count   <= 6'd0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            n_out        <= sw_s2;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            step_count   <= 6'd1;
            st_out       <= 1'b1;
            ph           <= 8'd0;
            state        <= STEP_HI;
          end
        end
        STEP_HI: begin
          if (ph == HALF_PERIOD - 8'd1) begin
            st_out <= 1'b0;
            ph     <= 8'd0;
            state  <= STEP_LO;
          end else begin
            ph <= ph + 8'd1;
          end
        end
        STEP_LO: begin
          if (ph != HALF_PERIOD - 8'd1) begin
            ph <= ph + 8'd1;
          end else if (done_sync[1]) begin
            state <= DONE;
`ifdef SQRT_SEQ_TIMEOUT_EN
          end else if (step_count >= MAX_STEPS) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= WAIT_REL;
`endif
          end else begin
            st_out <= 1'b1;
            ph     <= 8'd0;
            if (step_count != 6'd63) step_count <= step_count + 6'd1;
            state  <= STEP_HI;
          end
        end
        DONE: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= WAIT_REL;
        end
        WAIT_REL: begin
          // Level test: the release may already have happened during the run
          if (db_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_start_sequencer.sv
// tb/tb_sqrt_start_sequencer.sv - self-checking bench for sqrt_start_sequencer
module tb_sqrt_start_sequencer;
  localparam int HP  = 2;
  localparam int LAT = 2 + 4 + 1;
`ifdef SQRT_SEQ_TIMEOUT_EN
  localparam int K_NORM = 5;
  localparam int K_MAX  = 5;
`else
  localparam int K_NORM = 11;
  localparam int K_MAX  = 12;
`endif

  logic       clk = 1'b0;
  logic       rstN, key_n, done_in;
  logic [7:0] sw;
  logic [7:0] n_out;
  logic       st_out, busy, result_valid, timeout_err;
  logic [5:0] step_count;

  sqrt_start_sequencer #(
    .DEBOUNCE_CYCLES(16'd4),
    .HALF_PERIOD    (8'd2),
    .MAX_STEPS      (6'd6)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .key_n       (key_n),
    .sw          (sw),
    .done_in     (done_in),
    .n_out       (n_out),
    .st_out      (st_out),
    .busy        (busy),
    .result_valid(result_valid),
    .step_count  (step_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   edges = 0, gap = 0, done_target = 0, overlap = 0, any_busy = 0, lat = 0;
  logic st_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: counts st_out rises, checks period, raises done after the target rise
  task automatic tick();
    @(negedge clk);
    if (st_out && !st_prev) begin
      edges++;
      if (edges > 1) check("strobe_period", gap, 2 * HP);
      gap = 0;
    end
    gap++;
    st_prev = st_out;
    if (busy && result_valid) overlap++;
    if (busy) any_busy++;
    if (done_target > 0 && edges >= done_target) done_in = 1'b1;
  endtask

  task automatic press_wait();
    key_n = 1'b0;
    lat = 0;
    while (!busy && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_seq(input int k, input logic [7:0] v);
    int n;
    key_n = 1'b1;
    repeat (10) tick();
    sw = v; edges = 0; gap = 0; done_target = k; done_in = 1'b0;
    press_wait();
    check("press_latency", lat, LAT);
    check("busy_rise", busy, 1);
    check("rv_cleared", result_valid, 0);
    check("n_out_load", n_out, v);
    check("first_strobe_high", st_out, 1);
    check("step_count_first", step_count, 1);
    n = 0;
    while (busy && n < 400) begin
      sw = 8'($urandom);
      tick();
      n++;
    end
    check("seq_end_busy", busy, 0);
    check("seq_end_rv", result_valid, 1);
    check("seq_end_steps", step_count, k);
    check("seq_end_edges", edges, k);
    check("seq_end_st_low", st_out, 0);
    check("n_out_held", n_out, v);
    repeat (20) tick();
    check("no_extra_edge", edges, k);
    check("st_stays_low", st_out, 0);
    done_in = 1'b0;
    done_target = 0;
  endtask

  initial begin
    rstN = 1'b0; key_n = 1'b1; sw = 8'd0; done_in = 1'b0;
    repeat (3) tick();
    check("rst_n_out", n_out, 0);
    check("rst_st_out", st_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_steps", step_count, 0);
    check("rst_timeout", timeout_err, 0);
    rstN = 1'b1;
    repeat (8) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_st", st_out, 0);
    check("post_rst_n_out", n_out, 0);

    sw = 8'd100;
    any_busy = 0;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0; tick(); tick();
      key_n = 1'b1; tick(); tick();
    end
    repeat (6) tick();
    check("bounce_no_accept", any_busy, 0);

    do_seq(K_NORM, 8'd100);

    any_busy = 0;
    repeat (30) tick();
    check("repress_guard_busy", any_busy, 0);
    check("repress_guard_edges", edges, K_NORM);
    check("repress_guard_rv", result_valid, 1);

    for (int i = 0; i < 3; i++) do_seq(int'($urandom_range(1, K_MAX)), 8'($urandom_range(0, 255)));

    key_n = 1'b1;
    repeat (10) tick();
    edges = 0; gap = 0; done_target = 0;
    press_wait();
    lat = 0;
    while (!st_out && lat < 40) begin
      tick();
      lat++;
    end
    check("midrun_in_step_hi", st_out, 1);
    rstN = 1'b0;
    #1;
    check("midrun_st_drop", st_out, 0);
    check("midrun_busy", busy, 0);
    check("midrun_n_out", n_out, 0);
    check("midrun_steps", step_count, 0);
    check("midrun_rv", result_valid, 0);
    key_n = 1'b1; st_prev = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    repeat (10) tick();
    check("after_rst_busy", busy, 0);
    check("after_rst_st", st_out, 0);

    edges = 0; gap = 0; done_target = 0; done_in = 1'b0;
    press_wait();
    check("to_busy_rise", busy, 1);
`ifdef SQRT_SEQ_TIMEOUT_EN
    lat = 0;
    while (busy && lat < 200) begin
      tick();
      lat++;
    end
    check("to_edges", edges, 6);
    check("to_flag", timeout_err, 1);
    check("to_busy", busy, 0);
    check("to_rv", result_valid, 0);
    repeat (20) tick();
    check("to_no_extra_edge", edges, 6);
    check("to_st_low", st_out, 0);
`else
    repeat (60) tick();
    check("no_to_keeps_strobing", edges > 6, 1);
    check("no_to_flag", timeout_err, 0);
    check("no_to_busy", busy, 1);
`endif
    check("busy_rv_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
